// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module   : cpu_step_ctrl
// Purpose  : CPU clock-enable source: free-run divider or debounced single step,
//            with a halt latch that only Reset clears.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_step_ctrl #(
    parameter int DIV_COUNT       = 5000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mode,
    input  logic        step_btn,
    input  logic        halt,
    output logic        cpu_en,
    output logic        run_led,
    output logic        halted,
    output logic [15:0] step_count
);

    localparam int DW  = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV_COUNT - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STEP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   divider;
    logic [DW-1:0]   div_nxt;
    logic            en_nxt;
    logic            mode_m;
    logic            mode_s;
    logic            btn_m;
    logic            btn_s;
    logic [DBW-1:0]  cnt_db;
    logic            db_level;
    logic            db_prev;
    logic            press;

    // Two-flop synchronisers for the asynchronous switch and button
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_m <= 1'b0;
            mode_s <= 1'b0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            mode_m <= mode;
            mode_s <= mode_m;
            btn_m  <= step_btn;
            btn_s  <= btn_m;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_db   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            press    <= 1'b0;
        end else begin
            if (btn_s != db_level) begin
                if (cnt_db == DB_LAST) begin
                    db_level <= btn_s;
                    cnt_db   <= '0;
                end else begin
                    cnt_db <= cnt_db + 1'b1;
                end
            end else begin
                cnt_db <= '0;
            end
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_STEP;
            divider <= '0;
            cpu_en  <= 1'b0;
        end else begin
            state   <= state_nxt;
            divider <= div_nxt;
            cpu_en  <= en_nxt;
        end
    end

    // Priority: halt, then mode change, then pulse generation
    always_comb begin
        state_nxt = state;
        div_nxt   = divider;
        en_nxt    = 1'b0;
        if (halt) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_STEP: begin
                    if (mode_s) begin
                        state_nxt = ST_RUN;
                        div_nxt   = '0;
                    end else begin
                        en_nxt = press;
                    end
                end
                ST_RUN: begin
                    if (!mode_s) begin
                        state_nxt = ST_STEP;
                        div_nxt   = '0;
                    end else if (divider == DIV_LAST) begin
                        div_nxt = '0;
                        en_nxt  = 1'b1;
                    end else begin
                        div_nxt = divider + 1'b1;
                    end
                end
                ST_HALT: begin
                    state_nxt = ST_HALT;
                end
                default: begin
                    state_nxt = ST_STEP;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_led    <= 1'b0;
            halted     <= 1'b0;
            step_count <= 16'd0;
        end else begin
            run_led <= (state == ST_RUN);
            halted  <= (state == ST_HALT);
            if (cpu_en && (step_count != 16'hFFFF)) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module   : tb_cpu_step_ctrl
// Purpose  : Directed vector bench for cpu_step_ctrl (DIV_COUNT=4, DEBOUNCE_CYCLES=3).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_step_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mode;
    logic        step_btn;
    logic        halt;
    logic        cpu_en;
    logic        run_led;
    logic        halted;
    logic [15:0] step_count;

    int nvec  = 0;
    int nfail = 0;
    int dbl   = 0;
    logic prev_en = 1'b0;

    cpu_step_ctrl #(
        .DIV_COUNT       (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .mode       (mode),
        .step_btn   (step_btn),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .run_led    (run_led),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 Clk = ~Clk;

    // Watch for back-to-back enable pulses across the whole run
    always @(negedge Clk) begin
        if (cpu_en === 1'b1 && prev_en === 1'b1) dbl++;
        prev_en = cpu_en;
    end

    typedef struct {
        logic        rst;
        logic        md;
        logic        btn;
        logic        hlt;
        int          ncyc;
        logic        e_en;
        logic        e_run;
        logic        e_hlt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_count(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge Clk);
            #1;
            if (cpu_en === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    function automatic vec_t mk(input logic r, input logic m, input logic b, input logic h,
                                input int n, input logic en, input logic rn, input logic hl,
                                input logic [15:0] c);
        vec_t v;
        v.rst = r; v.md = m; v.btn = b; v.hlt = h; v.ncyc = n;
        v.e_en = en; v.e_run = rn; v.e_hlt = hl; v.e_cnt = c;
        return v;
    endfunction

    initial begin
        int p;
        int f;

        // Reset/idle, RUN cadence, halt on divider terminal, halt latch, reset recovery
        vecs[0]  = mk(1, 0, 0, 0,  2, 0, 0, 0, 16'd0);
        vecs[1]  = mk(0, 0, 0, 0, 50, 0, 0, 0, 16'd0);
        vecs[2]  = mk(0, 1, 0, 0,  3, 0, 0, 0, 16'd0);
        vecs[3]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 16'd0);
        vecs[4]  = mk(0, 1, 0, 0,  2, 0, 1, 0, 16'd0);
        vecs[5]  = mk(0, 1, 0, 0,  1, 1, 1, 0, 16'd0);
        vecs[6]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 16'd1);
        vecs[7]  = mk(0, 1, 0, 0,  3, 1, 1, 0, 16'd1);
        vecs[8]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 16'd2);
        vecs[9]  = mk(0, 1, 0, 0, 32, 0, 1, 0, 16'd10);
        vecs[10] = mk(0, 1, 0, 0,  2, 0, 1, 0, 16'd10);
        vecs[11] = mk(0, 1, 0, 1,  1, 0, 1, 0, 16'd10);
        vecs[12] = mk(0, 1, 0, 0,  1, 0, 0, 1, 16'd10);
        vecs[13] = mk(0, 0, 1, 0, 20, 0, 0, 1, 16'd10);
        vecs[14] = mk(0, 1, 0, 0, 20, 0, 0, 1, 16'd10);
        vecs[15] = mk(1, 0, 0, 0,  1, 0, 0, 0, 16'd0);
        vecs[16] = mk(0, 0, 0, 0,  2, 0, 0, 0, 16'd0);

        Reset = 1'b1; mode = 1'b0; step_btn = 1'b0; halt = 1'b0;

        for (int i = 0; i < 17; i++) begin
            Reset = vecs[i].rst; mode = vecs[i].md; step_btn = vecs[i].btn; halt = vecs[i].hlt;
            repeat (vecs[i].ncyc) @(posedge Clk);
            #1;
            check($sformatf("v%0d cpu_en", i),     int'(cpu_en),     int'(vecs[i].e_en));
            check($sformatf("v%0d run_led", i),    int'(run_led),    int'(vecs[i].e_run));
            check($sformatf("v%0d halted", i),     int'(halted),     int'(vecs[i].e_hlt));
            check($sformatf("v%0d step_count", i), int'(step_count), int'(vecs[i].e_cnt));
        end

        // Bouncy press: one pulse on the 7th edge after the stable rise
        step_btn = 1'b1; run_count(1, p, f); check("bounce1", p, 0);
        step_btn = 1'b0; run_count(1, p, f); check("bounce2", p, 0);
        step_btn = 1'b1; run_count(1, p, f); check("bounce3", p, 0);
        step_btn = 1'b0; run_count(1, p, f); check("bounce4", p, 0);
        step_btn = 1'b1; run_count(20, p, f);
        check("press1 pulses", p, 1);
        check("press1 latency", f, 7);
        step_btn = 1'b0; run_count(10, p, f);
        check("release pulses", p, 0);
        step_btn = 1'b1; run_count(10, p, f);
        check("press2 pulses", p, 1);
        check("press2 latency", f, 7);
        check("press2 step_count", int'(step_count), 2);

        // Reset for one cycle in the middle of debouncing a held button
        Reset = 1'b1; step_btn = 1'b0; run_count(2, p, f);
        Reset = 1'b0; step_btn = 1'b1; run_count(4, p, f);
        check("middb pulses", p, 0);
        Reset = 1'b1; run_count(1, p, f);
        check("middb reset pulses", p, 0);
        check("middb reset count", int'(step_count), 0);
        Reset = 1'b0; run_count(12, p, f);
        check("after reset pulses", p, 1);
        check("after reset latency", f, 7);
        check("after reset count", int'(step_count), 1);

        // Saturation: preload near the top, then let RUN pulses push it over
        Reset = 1'b1; step_btn = 1'b0; run_count(2, p, f);
        Reset = 1'b0; mode = 1'b1; run_count(20, p, f);
        check("run pulses", p, 4);
        check("run first pulse", f, 7);
        check("run count", int'(step_count), 4);
        force dut.step_count = 16'hFFFD;
        @(negedge Clk);
        release dut.step_count;
        run_count(20, p, f);
        check("sat pulses", p, 5);
        check("sat step_count", int'(step_count), 16'hFFFF);

        check("no back-to-back cpu_en", dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
